avr_io_irqctl: RTL and testbench

//   Parametrised interrupt controller for the soft AVR core. Replaces the fixed 4-line priority encoder.

---
 rtl/avr_io_irqctl.sv | 128 ++++++++++++
 tb/tb_avr_io_irqctl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_io_irqctl.sv
// Interrupt controller on an avr_io_* slot: latched edge/level requests, mask, priority vector.
// Define AVR_IRQCTL_SYNC_EN to pass irq_in through a 2-flop synchroniser per bit.
module avr_io_irqctl #(
  parameter int NUM_IRQ = 8,
  parameter int VECT_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               io_re,
  input  logic               io_we,
  input  logic [1:0]         io_a,
  output logic [7:0]         io_di,
  input  logic [7:0]         io_do,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               iflag,
  output logic [VECT_W-1:0]  ivect,
  input  logic               iack,
  input  logic [VECT_W-1:0]  iack_vect
);

  logic [NUM_IRQ-1:0] en;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] mode;
  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] s_q;
  logic [NUM_IRQ-1:0] pend_nx;
  logic [NUM_IRQ-1:0] ack_hit;
  logic [NUM_IRQ-1:0] act;
  logic [VECT_W-1:0]  win;
  logic [7:0]         status;
  logic               we_en;
  logic               we_pend;
  logic               we_mode;
  logic               we_trig;

`ifdef AVR_IRQCTL_SYNC_EN
  logic [NUM_IRQ-1:0] sync1;
  logic [NUM_IRQ-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = irq_in;
`endif

  assign we_en   = io_we && (io_a == 2'd0);
  assign we_pend = io_we && (io_a == 2'd1);
  assign we_mode = io_we && (io_a == 2'd2);
  assign we_trig = io_we && (io_a == 2'd3);
  assign act     = pend & en;

  // Edge bits: set (edge or trigger) beats clear (W1C or ack)
  always_comb begin
    ack_hit = '0;
    pend_nx = pend;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_hit[i] = iack && (iack_vect == VECT_W'(i));
      if (mode[i]) begin
        if ((s[i] && !s_q[i]) || (we_trig && io_do[i]))
          pend_nx[i] = 1'b1;
        else if ((we_pend && io_do[i]) || ack_hit[i])
          pend_nx[i] = 1'b0;
      end else begin
        pend_nx[i] = s[i];
      end
    end
  end

  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (act[i])
        win = VECT_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en      <= '0;
      pend    <= '0;
      mode    <= '0;
      s_q     <= '0;
      irq_ack <= '0;
      iflag   <= 1'b0;
      ivect   <= '0;
    end else begin
      if (we_en)
        en <= io_do[NUM_IRQ-1:0];
      if (we_mode)
        mode <= io_do[NUM_IRQ-1:0];
      pend    <= pend_nx;
      s_q     <= s;
      irq_ack <= ack_hit;
      iflag   <= |act;
      ivect   <= win;
    end
  end

  always_comb begin
    status = 8'h00;
    status[7] = iflag;
    status[VECT_W-1:0] = ivect;
  end

  always_comb begin
    io_di = 8'h00;
    if (io_re) begin
      unique case (io_a)
        2'd0: io_di = 8'(en);
        2'd1: io_di = 8'(pend);
        2'd2: io_di = 8'(mode);
        2'd3: io_di = status;
        default: io_di = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_avr_io_irqctl.sv
// Directed bench for avr_io_irqctl: reset, edge/level capture, priority,
// ack pulses, W1C vs set, software trigger, enable masking, async reset.
module tb_avr_io_irqctl;

  logic       clk;
  logic       rst_n;
  logic       io_re;
  logic       io_we;
  logic [1:0] io_a;
  logic [7:0] io_di;
  logic [7:0] io_do;
  logic [7:0] irq_in;
  logic [7:0] irq_ack;
  logic       iflag;
  logic [2:0] ivect;
  logic       iack;
  logic [2:0] iack_vect;

  int tests;
  int fails;
  logic [7:0] d;

  avr_io_irqctl #(.NUM_IRQ(8), .VECT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .io_re(io_re), .io_we(io_we), .io_a(io_a),
    .io_di(io_di), .io_do(io_do),
    .irq_in(irq_in), .irq_ack(irq_ack),
    .iflag(iflag), .ivect(ivect),
    .iack(iack), .iack_vect(iack_vect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    io_we = 1'b1;
    io_a  = a;
    io_do = v;
    tick();
    io_we = 1'b0;
    io_do = 8'h00;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    io_re = 1'b1;
    io_a  = a;
    #1;
    v = io_di;
    io_re = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), d);
      tests++;
      if (d !== 8'h00) begin
        fails++;
        $display("FAIL reset_reg%0d got %h want 00", i, d);
      end
    end
    tests++;
    if (iflag !== 1'b0 || ivect !== 3'd0) begin
      fails++;
      $display("FAIL reset_iflag got %b/%0d want 0/0", iflag, ivect);
    end
    tests++;
    if (irq_ack !== 8'h00) begin
      fails++;
      $display("FAIL reset_ack got %h want 00", irq_ack);
    end
    io_a = 2'd1;
    #1;
    tests++;
    if (io_di !== 8'h00) begin
      fails++;
      $display("FAIL idle_bus got %h want 00", io_di);
    end
  endtask

  task automatic test_edge_basic();
    wr(2'd2, 8'hFF);
    wr(2'd0, 8'hFF);
    irq_in = 8'h20;
    tick();
    irq_in = 8'h00;
    rd(2'd1, d);
    tests++;
    if (d !== 8'h20 || iflag !== 1'b0) begin
      fails++;
      $display("FAIL edge_pend got %h/%b want 20/0", d, iflag);
    end
    tick();
    tests++;
    if (iflag !== 1'b1 || ivect !== 3'd5) begin
      fails++;
      $display("FAIL edge_iflag got %b/%0d want 1/5", iflag, ivect);
    end
    iack = 1'b1;
    iack_vect = 3'd5;
    tick();
    iack = 1'b0;
    rd(2'd1, d);
    tests++;
    if (irq_ack !== 8'h20 || d !== 8'h00) begin
      fails++;
      $display("FAIL edge_ack got ack=%h pend=%h want 20/00", irq_ack, d);
    end
    tick();
    tests++;
    if (irq_ack !== 8'h00 || iflag !== 1'b0) begin
      fails++;
      $display("FAIL edge_ack_end got ack=%h iflag=%b want 00/0", irq_ack, iflag);
    end
  endtask

  task automatic test_priority();
    irq_in = 8'h44;
    tick();
    irq_in = 8'h00;
    tick();
    tests++;
    if (iflag !== 1'b1 || ivect !== 3'd2) begin
      fails++;
      $display("FAIL prio_first got %b/%0d want 1/2", iflag, ivect);
    end
    iack = 1'b1;
    iack_vect = 3'd2;
    tick();
    iack = 1'b0;
    tick();
    tests++;
    if (iflag !== 1'b1 || ivect !== 3'd6) begin
      fails++;
      $display("FAIL prio_second got %b/%0d want 1/6", iflag, ivect);
    end
    iack = 1'b1;
    iack_vect = 3'd6;
    tick();
    iack = 1'b0;
    tick();
    tests++;
    if (iflag !== 1'b0) begin
      fails++;
      $display("FAIL prio_done got iflag=%b want 0", iflag);
    end
  endtask

  task automatic test_level();
    wr(2'd2, 8'h00);
    wr(2'd0, 8'h01);
    irq_in = 8'h01;
    tick();
    tick();
    iack = 1'b1;
    iack_vect = 3'd0;
    io_we = 1'b1;
    io_a = 2'd1;
    io_do = 8'h01;
    tick();
    iack = 1'b0;
    io_we = 1'b0;
    io_do = 8'h00;
    rd(2'd1, d);
    tests++;
    if (irq_ack !== 8'h01 || d !== 8'h01) begin
      fails++;
      $display("FAIL level_ack got ack=%h pend=%h want 01/01", irq_ack, d);
    end
    tick();
    tests++;
    if (iflag !== 1'b1 || ivect !== 3'd0) begin
      fails++;
      $display("FAIL level_hold got %b/%0d want 1/0", iflag, ivect);
    end
    irq_in = 8'h00;
    tick();
    rd(2'd1, d);
    tests++;
    if (d !== 8'h00 || iflag !== 1'b1) begin
      fails++;
      $display("FAIL level_drop got pend=%h iflag=%b want 00/1", d, iflag);
    end
    tick();
    tests++;
    if (iflag !== 1'b0) begin
      fails++;
      $display("FAIL level_off got iflag=%b want 0", iflag);
    end
  endtask

  task automatic test_set_wins();
    wr(2'd2, 8'hFF);
    wr(2'd0, 8'hFF);
    irq_in = 8'h08;
    io_we = 1'b1;
    io_a = 2'd1;
    io_do = 8'h08;
    tick();
    irq_in = 8'h00;
    io_we = 1'b0;
    io_do = 8'h00;
    rd(2'd1, d);
    tests++;
    if (d !== 8'h08) begin
      fails++;
      $display("FAIL set_wins got %h want 08", d);
    end
    wr(2'd1, 8'h08);
    rd(2'd1, d);
    tests++;
    if (d !== 8'h00) begin
      fails++;
      $display("FAIL w1c got %h want 00", d);
    end
    wr(2'd2, 8'h10);
    wr(2'd3, 8'h11);
    rd(2'd1, d);
    tests++;
    if (d !== 8'h10) begin
      fails++;
      $display("FAIL sw_trig got %h want 10", d);
    end
    tick();
    rd(2'd3, d);
    tests++;
    if (d !== 8'h84) begin
      fails++;
      $display("FAIL status got %h want 84", d);
    end
    wr(2'd1, 8'h10);
    tick();
  endtask

  task automatic test_enable_mask();
    wr(2'd2, 8'hFF);
    wr(2'd0, 8'h00);
    irq_in = 8'h80;
    tick();
    irq_in = 8'h00;
    tick();
    rd(2'd1, d);
    tests++;
    if (d !== 8'h80 || iflag !== 1'b0) begin
      fails++;
      $display("FAIL mask_hide got pend=%h iflag=%b want 80/0", d, iflag);
    end
    wr(2'd0, 8'h80);
    tick();
    tests++;
    if (iflag !== 1'b1 || ivect !== 3'd7) begin
      fails++;
      $display("FAIL mask_show got %b/%0d want 1/7", iflag, ivect);
    end
    #2;
    rst_n = 1'b0;
    #1;
    rd(2'd1, d);
    tests++;
    if (iflag !== 1'b0 || ivect !== 3'd0 || irq_ack !== 8'h00 || d !== 8'h00) begin
      fails++;
      $display("FAIL async_rst got iflag=%b ivect=%0d ack=%h pend=%h want 0/0/00/00",
               iflag, ivect, irq_ack, d);
    end
    tick();
    rst_n = 1'b1;
    tick();
    iack = 1'b1;
    iack_vect = 3'd1;
    tick();
    iack = 1'b0;
    rd(2'd1, d);
    tests++;
    if (irq_ack !== 8'h02 || d !== 8'h00) begin
      fails++;
      $display("FAIL idle_ack got ack=%h pend=%h want 02/00", irq_ack, d);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    io_re = 1'b0;
    io_we = 1'b0;
    io_a = 2'd0;
    io_do = 8'h00;
    irq_in = 8'h00;
    iack = 1'b0;
    iack_vect = 3'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_edge_basic();
    test_priority();
    test_level();
    test_set_wins();
    test_enable_mask();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
